// File: rtl/mono_rx_fifo_arbiter.sv
// Round-robin, burst-limited merge of N first-word-fall-through source FIFOs
// into a single registered output word feeding bram_fifo.
module mono_rx_fifo_arbiter #(
   parameter int N         = 4,
   parameter int DW        = 32,
   parameter int MAX_BURST = 16
) (
   input  logic            BUS_CLK,
   input  logic            BUS_RST_N,
   input  logic [N-1:0]    ENABLE,
   input  logic [N-1:0]    IN_EMPTY,
   input  logic [N*DW-1:0] IN_DATA,
   output logic [N-1:0]    IN_READ,
   input  logic            OUT_READ,
   output logic            OUT_EMPTY,
   output logic [DW-1:0]   OUT_DATA,
   output logic [N-1:0]    GRANT,
   output logic [31:0]     WORD_CNT
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [7:0] MAXB = 8'(MAX_BURST);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t        state_r, state_nxt_s;
   logic [N-1:0]  grant_r, grant_nxt_s;
   logic [IW-1:0] gidx_r, gidx_nxt_s, last_r, last_nxt_s, sel_idx_s;
   logic          sel_found_s;
   logic [7:0]    burst_r, burst_nxt_s, burst_inc_s;
   logic          out_empty_r;
   logic [DW-1:0] out_data_r, sel_data_s;
   logic [31:0]   word_cnt_r;
   logic [N-1:0]  req_s, in_read_s;
   logic          space_s, pop_s, release_s;

   assign req_s      = ENABLE & ~IN_EMPTY;
   assign space_s    = out_empty_r | OUT_READ;
   assign sel_data_s = IN_DATA[gidx_r*DW +: DW];

   // Round-robin search starting one past the last released source
   always_comb begin
      logic [IW-1:0] idx_v;
      logic          hit_v;
      idx_v       = '0;
      hit_v       = 1'b0;
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      for (int k = 1; k <= N; k++) begin
         idx_v       = IW'((int'(last_r) + k) % N);
         hit_v       = ~sel_found_s & req_s[idx_v];
         sel_idx_s   = hit_v ? idx_v : sel_idx_s;
         sel_found_s = sel_found_s | hit_v;
      end
   end

   // Pop strobe for the granted source and the release decision
   always_comb begin
      pop_s       = 1'b0;
      release_s   = 1'b0;
      in_read_s   = '0;
      burst_inc_s = burst_r;
      if (state_r == ST_GRANT) begin
         pop_s       = req_s[gidx_r] & space_s & (burst_r < MAXB);
         burst_inc_s = burst_r + {7'd0, pop_s};
         // the burst limit counts the pop taking place on this same edge
         release_s   = (burst_inc_s == MAXB) | (IN_EMPTY[gidx_r] & ~pop_s) | ~ENABLE[gidx_r];
         in_read_s[gidx_r] = pop_s;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Next-state: IDLE arbitrates for one cycle, GRANT bursts until release
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      gidx_nxt_s  = gidx_r;
      last_nxt_s  = last_r;
      burst_nxt_s = burst_r;
      case (state_r)
         ST_IDLE: begin
            if (sel_found_s) begin
               state_nxt_s            = ST_GRANT;
               grant_nxt_s            = '0;
               grant_nxt_s[sel_idx_s] = 1'b1;
               gidx_nxt_s             = sel_idx_s;
               burst_nxt_s            = 8'd0;
            end else begin
               grant_nxt_s = '0;
            end
         end
         ST_GRANT: begin
            burst_nxt_s = burst_inc_s;
            if (release_s) begin
               state_nxt_s = ST_IDLE;
               grant_nxt_s = '0;
               last_nxt_s  = gidx_r;
            end else begin
               state_nxt_s = ST_GRANT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = '0;
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_r <= ST_IDLE;
         grant_r <= '0;
         gidx_r  <= '0;
         last_r  <= IW'(N - 1);
         burst_r <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         gidx_r  <= gidx_nxt_s;
         last_r  <= last_nxt_s;
         burst_r <= burst_nxt_s;
      end
   end

   // Output word register and saturating forwarded-word counter
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         out_empty_r <= 1'b1;
         out_data_r  <= '0;
         word_cnt_r  <= 32'd0;
      end else if (pop_s) begin
         out_data_r  <= sel_data_s;
         out_empty_r <= 1'b0;
         word_cnt_r  <= (word_cnt_r == 32'hFFFF_FFFF) ? word_cnt_r : word_cnt_r + 32'd1;
      end else if (OUT_READ) begin
         out_empty_r <= 1'b1;
      end else begin
         out_empty_r <= out_empty_r;
      end
   end

   assign IN_READ   = in_read_s;
   assign OUT_EMPTY = out_empty_r;
   assign OUT_DATA  = out_data_r;
   assign GRANT     = grant_r;
   assign WORD_CNT  = word_cnt_r;

endmodule
